// File: rtl/barrett_mod_reduce.sv
// barrett_mod_reduce: (a*b) mod P via Barrett reduction, one op in flight.
// Issues a*b, x_hi*MU and q*P to an external multiplier, then corrects r < P.
//
// Ports (flattened AXI-stream channels, val/rdy handshakes):
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_mul_*   (sink)       request, dat = {b, a}, plus sop/eop/ctl
//   o_mul_*   (source)     result r < P, with request sop/eop/ctl, err, mod=0
//   o_mult_*  (source)     operands to the multiplier, dat = {b, a},
//                          ctl[1:0] = stage code (AB=1, MU=2, QP=3)
//   i_mult_*  (sink)       products returned by the multiplier
//
// Optional build macro BARRETT_RANGE_CHECK_EN: flags a >= P or b >= P
// through o_mul_err (the computation still runs).

module barrett_mod_reduce #(
  parameter int unsigned DAT_BITS  = 8,
  parameter int unsigned CTL_BITS  = 8,
  parameter int unsigned MCTL_BITS = 8,
  parameter int unsigned P         = 101,
  parameter int unsigned MU        = 162
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_mul_val,
  output logic                  i_mul_rdy,
  input  logic [2*DAT_BITS-1:0] i_mul_dat,
  input  logic                  i_mul_sop,
  input  logic                  i_mul_eop,
  input  logic [CTL_BITS-1:0]   i_mul_ctl,

  output logic                  o_mul_val,
  input  logic                  o_mul_rdy,
  output logic [DAT_BITS-1:0]   o_mul_dat,
  output logic                  o_mul_sop,
  output logic                  o_mul_eop,
  output logic [CTL_BITS-1:0]   o_mul_ctl,
  output logic                  o_mul_err,
  output logic                  o_mul_mod,

  output logic                  o_mult_val,
  input  logic                  o_mult_rdy,
  output logic [2*DAT_BITS-1:0] o_mult_dat,
  output logic                  o_mult_sop,
  output logic                  o_mult_eop,
  output logic [MCTL_BITS-1:0]  o_mult_ctl,

  input  logic                  i_mult_val,
  output logic                  i_mult_rdy,
  input  logic [2*DAT_BITS-1:0] i_mult_dat,
  input  logic [MCTL_BITS-1:0]  i_mult_ctl
);

  localparam int unsigned K = DAT_BITS - 1;
  localparam int unsigned W = DAT_BITS + 1;

  localparam logic [DAT_BITS-1:0] P_D  = DAT_BITS'(P);
  localparam logic [DAT_BITS-1:0] MU_D = DAT_BITS'(MU);
  localparam logic [W-1:0]        P_W  = W'(P);
  localparam logic [W-1:0]        P2_W = W'(2 * P);

  typedef enum logic [3:0] {
    IDLE,
    ISS_AB,
    WT_AB,
    ISS_MU,
    WT_MU,
    ISS_QP,
    WT_QP,
    CORR,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [CTL_BITS-1:0]   ctl_q, ctl_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  err_q, err_d;
  logic [W-1:0]          x_q, x_d;
  logic [W-1:0]          qp_q, qp_d;

  logic                  o_mult_val_q, o_mult_val_d;
  logic [2*DAT_BITS-1:0] o_mult_dat_q, o_mult_dat_d;
  logic [MCTL_BITS-1:0]  o_mult_ctl_q, o_mult_ctl_d;

  logic                  o_mul_val_q, o_mul_val_d;
  logic [DAT_BITS-1:0]   o_mul_dat_q, o_mul_dat_d;
  logic [CTL_BITS-1:0]   o_mul_ctl_q, o_mul_ctl_d;
  logic                  o_mul_sop_q, o_mul_sop_d;
  logic                  o_mul_eop_q, o_mul_eop_d;
  logic                  o_mul_err_q, o_mul_err_d;

  logic [W-1:0]          r0, r1, r2;
  logic [DAT_BITS-1:0]   r_sel;

  // Only ctl[1:0] carries the stage code back.
  logic unused_mult_ctl;
  assign unused_mult_ctl = ^i_mult_ctl;

  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    err_d        = err_q;
    x_d          = x_q;
    qp_d         = qp_q;
    o_mult_val_d = o_mult_val_q;
    o_mult_dat_d = o_mult_dat_q;
    o_mult_ctl_d = o_mult_ctl_q;
    o_mul_val_d  = o_mul_val_q;
    o_mul_dat_d  = o_mul_dat_q;
    o_mul_ctl_d  = o_mul_ctl_q;
    o_mul_sop_d  = o_mul_sop_q;
    o_mul_eop_d  = o_mul_eop_q;
    o_mul_err_d  = o_mul_err_q;

    // Only the low W bits of x and q*P matter: r0 < 3P fits in W bits,
    // and r1/r2 lie in (-2^DAT_BITS, 2^DAT_BITS) so the MSB is their sign.
    r0 = x_q - qp_q;
    r1 = r0 - P_W;
    r2 = r0 - P2_W;
    if (!r2[W-1]) begin
      r_sel = r2[DAT_BITS-1:0];
    end else if (!r1[W-1]) begin
      r_sel = r1[DAT_BITS-1:0];
    end else begin
      r_sel = r0[DAT_BITS-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (i_mul_val) begin
          ctl_d        = i_mul_ctl;
          sop_d        = i_mul_sop;
          eop_d        = i_mul_eop;
`ifdef BARRETT_RANGE_CHECK_EN
          err_d        = (i_mul_dat[DAT_BITS-1:0] >= P_D) ||
                         (i_mul_dat[2*DAT_BITS-1:DAT_BITS] >= P_D);
`else
          err_d        = 1'b0;
`endif
          o_mult_val_d = 1'b1;
          o_mult_dat_d = i_mul_dat;
          o_mult_ctl_d = MCTL_BITS'(1);
          state_d      = ISS_AB;
        end
      end
      ISS_AB: begin
        if (o_mult_rdy) begin
          o_mult_val_d = 1'b0;
          state_d      = WT_AB;
        end
      end
      WT_AB: begin
        if (i_mult_val) begin
          x_d = i_mult_dat[W-1:0];
          if (i_mult_ctl[1:0] != 2'd1) begin
            err_d = 1'b1;
          end
          // Top DAT_BITS bits of x, i.e. x >> (K-1).
          o_mult_val_d = 1'b1;
          o_mult_dat_d = {MU_D, i_mult_dat[2*K-1:K-1]};
          o_mult_ctl_d = MCTL_BITS'(2);
          state_d      = ISS_MU;
        end
      end
      ISS_MU: begin
        if (o_mult_rdy) begin
          o_mult_val_d = 1'b0;
          state_d      = WT_MU;
        end
      end
      WT_MU: begin
        if (i_mult_val) begin
          if (i_mult_ctl[1:0] != 2'd2) begin
            err_d = 1'b1;
          end
          // q = prod_mu >> (K+1)
          o_mult_val_d = 1'b1;
          o_mult_dat_d = {P_D, i_mult_dat[2*DAT_BITS-1:K+1]};
          o_mult_ctl_d = MCTL_BITS'(3);
          state_d      = ISS_QP;
        end
      end
      ISS_QP: begin
        if (o_mult_rdy) begin
          o_mult_val_d = 1'b0;
          state_d      = WT_QP;
        end
      end
      WT_QP: begin
        if (i_mult_val) begin
          qp_d = i_mult_dat[W-1:0];
          if (i_mult_ctl[1:0] != 2'd3) begin
            err_d = 1'b1;
          end
          state_d = CORR;
        end
      end
      CORR: begin
        o_mul_val_d = 1'b1;
        o_mul_dat_d = r_sel;
        o_mul_ctl_d = ctl_q;
        o_mul_sop_d = sop_q;
        o_mul_eop_d = eop_q;
        o_mul_err_d = err_q;
        state_d     = OUT;
      end
      OUT: begin
        if (o_mul_rdy) begin
          o_mul_val_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ctl_q        <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
      x_q          <= '0;
      qp_q         <= '0;
      o_mult_val_q <= 1'b0;
      o_mult_dat_q <= '0;
      o_mult_ctl_q <= '0;
      o_mul_val_q  <= 1'b0;
      o_mul_dat_q  <= '0;
      o_mul_ctl_q  <= '0;
      o_mul_sop_q  <= 1'b0;
      o_mul_eop_q  <= 1'b0;
      o_mul_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      err_q        <= err_d;
      x_q          <= x_d;
      qp_q         <= qp_d;
      o_mult_val_q <= o_mult_val_d;
      o_mult_dat_q <= o_mult_dat_d;
      o_mult_ctl_q <= o_mult_ctl_d;
      o_mul_val_q  <= o_mul_val_d;
      o_mul_dat_q  <= o_mul_dat_d;
      o_mul_ctl_q  <= o_mul_ctl_d;
      o_mul_sop_q  <= o_mul_sop_d;
      o_mul_eop_q  <= o_mul_eop_d;
      o_mul_err_q  <= o_mul_err_d;
    end
  end

  assign i_mul_rdy  = (state_q == IDLE);
  assign i_mult_rdy = (state_q == WT_AB) ||
                      (state_q == WT_MU) ||
                      (state_q == WT_QP);

  assign o_mult_val = o_mult_val_q;
  assign o_mult_dat = o_mult_dat_q;
  assign o_mult_ctl = o_mult_ctl_q;
  assign o_mult_sop = 1'b1;
  assign o_mult_eop = 1'b1;

  assign o_mul_val  = o_mul_val_q;
  assign o_mul_dat  = o_mul_dat_q;
  assign o_mul_ctl  = o_mul_ctl_q;
  assign o_mul_sop  = o_mul_sop_q;
  assign o_mul_eop  = o_mul_eop_q;
  assign o_mul_err  = o_mul_err_q;
  assign o_mul_mod  = 1'b0;

endmodule

// File: doc/barrett_mod_reduce.md
# barrett_mod_reduce

- Downstream companion to the pipelined `multiplier` block: computes `(a*b) mod P` using Barrett reduction.
- Issues three multiplications, one at a time, to an external `multiplier` instance through a pair of AXI-stream ports, then applies a single-cycle conditional-subtract correction.
- Handles one operation in flight, so it is meant for low-rate field arithmetic, such as scalar/control paths of the prover.

## Interface
- `DAT_BITS`, 8: operand width of the attached multiplier. Reduction width is `K = DAT_BITS-1`.
- `CTL_BITS`, 8: width of the user control field carried from `i_mul` to `o_mul`.
- `MCTL_BITS`, 8: ctl width of the attached multiplier. Must be ≥2.
- `P`, 101: modulus. Requirement: `2^(K-1) < P < 2^K`.
- `MU`, 162: `floor(2^(2K)/P)`. Fits in `DAT_BITS` bits by construction.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_mul`, if_axi_stream.sink, dat `2*DAT_BITS`: request. `a = dat[DAT_BITS-1:0]`, `b = dat[2*DAT_BITS-1:DAT_BITS]`. Also carries sop/eop/ctl.
- `o_mul`, if_axi_stream.source, dat `DAT_BITS`: result `r < P`. Carries the request's sop/eop/ctl.
- `o_mult`, if_axi_stream.source, dat `2*DAT_BITS`: operands to the multiplier, packed the same way as `i_mul`.
- `i_mult`, if_axi_stream.sink, dat `2*DAT_BITS`: products returned by the multiplier.

## Operation
- **FSM states:** IDLE → ISS_AB → WT_AB → ISS_MU → WT_MU → ISS_QP → WT_QP → CORR → OUT → IDLE.
- **IDLE:**
  - `i_mul.rdy=1`.
  - On `val&rdy`, capture a, b, ctl, sop and eop, then go to ISS_AB.
- **ISS_*:**
  - `o_mult.val=1` with that stage's operands.
  - `o_mult.ctl[1:0]` = stage code (AB=1, MU=2, QP=3); upper ctl bits are 0.
  - Operands are held stable until `o_mult.rdy`, then go to WT_*.
- **WT_*:**
  - `i_mult.rdy=1`.
  - On `i_mult.val`, capture the product and advance.
  - A returned product whose `ctl[1:0]` does not match the stage code is still consumed, but `err_q` is set. The result is still delivered, with `err=1`.
- **Arithmetic:**
  - `x = a*b`, which is `< 2^(2K)`.
  - MU stage operands: `x[2K-1:K-1]` (`DAT_BITS` bits) and `MU`.
  - `q = prod_mu >> (K+1)`, which is `< 2^DAT_BITS`.
  - QP stage operands: `q` and `P`.
  - In CORR, compute in `DAT_BITS+1` bits modulo `2^(DAT_BITS+1)`: `r0 = x - qP`, `r1 = r0-P`, `r2 = r0-2P`.
  - Select the smallest non-negative of the three. `r0 < 3P` is guaranteed.
- **OUT:**
  - `o_mul.val=1`; dat, ctl, sop, eop and err are held until `o_mul.rdy`, then return to IDLE.
  - `o_mul.mod=0`.
- **Reset values:**
  - State = IDLE.
  - `i_mul.rdy=1` (combinational from IDLE).
  - `o_mul.val=0`, `o_mult.val=0`, `i_mult.rdy=0`.
  - `o_mul.dat`, `ctl`, `sop`, `eop` and `err` = 0.
  - `o_mult.dat=0`, `o_mult.ctl=0`.
- **Boundary conditions:**
  - `a=0` or `b=0` gives `r=0`.
  - A new request while busy is not accepted (`i_mul.rdy=0` outside IDLE).
  - Reset mid-operation returns to IDLE in one cycle and discards in-flight state.
  - The system must also reset the attached multiplier; a product arriving after reset while in IDLE is ignored (`i_mult.rdy=0`).

## Timing
- Let `L` = multiplier accept-to-`val` latency. `L=4` with `o_mult.rdy` constantly high.
- With no backpressure:
  - Accept at t0; ISS_AB at t0+1.
  - Products arrive at t0+1+L, t0+2+2L and t0+3+3L.
  - CORR at t0+4+3L; `o_mul.val` at t0+5+3L. That is 17 cycles for L=4.
- Throughput is one result per `6+3L` cycles, including the IDLE accept cycle.
- `o_mult.val`/`o_mult.dat` and `o_mul.val`/`o_mul.dat` are registered outputs.
- `i_mul.rdy` and `i_mult.rdy` are combinational from state only, never from a valid input.

## Configuration
- **`BARRETT_RANGE_CHECK_EN` defined:**
  - In IDLE on accept, sets `err_q` if `a ≥ P` or `b ≥ P`. The computation still runs and `o_mul.err=1`.
  - The result is undefined-but-deterministic (same algorithm, same correction) when `x ≥ 2^(2K)`.
- **Not defined:** no range comparator is built; `o_mul.err` reflects only the ctl-mismatch check.

## Test plan
All with `DAT_BITS=8`, `P=101`, `MU=162`, and the real `multiplier` attached.
- `a=100,b=100`: intermediates are `x=10000`, `q=98`, `r0=102`. Require `o_mul.dat=1`, `err=0`, and `o_mul.val` exactly 17 cycles after accept.
- Back-to-back requests `(0,57)`, `(1,100)`, `(50,2)` with ctl 0x11/0x22/0x33 and sop/eop patterns. Require results 0, 100, 100 in order with matching ctl/sop/eop, and `i_mul.rdy=0` between accepts.
- Random `o_mul.rdy` and `o_mult.rdy` deassertion (50%) over 1000 random `a,b < 101`. Require results equal `(a*b)%101`, and dat/val held stable while stalled.
- Assert `i_rst` for 1 cycle while in WT_MU, then reset the multiplier. Require IDLE next cycle, `o_mul.val=0`, and that a following `(7,9)` returns 63.
- Force a returned `i_mult.ctl[1:0]=2` during WT_AB. Require the result is delivered with `err=1`.
- With `BARRETT_RANGE_CHECK_EN`: `a=101,b=3` gives `err=1`. Without it: `a=5,b=5` gives `dat=25`, `err=0`.
